multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Moore-style main control FSM for the multicycle variant of the MIPS core. It sequences the shared datapath resources over several cycles per instruction: ALU operand muxes, memory address mux, PC source, and the destination-register mux (reg_dst: 0 selects rt, 1 selects rd). It supports R-type, lw, sw, beq, addi and j. A mem_ready handshake stretches the memory-access states.

Parameters:
STATE_W, 4, width of the state register and the state_dbg port

Ports:
clk  input  1  system clock, all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
opcode  input  6  instruction[31:26] from the instruction register; sampled in DECODE and MEMADR
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
branch  output  1  PC load qualified by ALU zero (datapath ANDs with zero)
iord  output  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_dst  output  1  write-register mux select: 0 = rt, 1 = rd
mem_to_reg  output  1  write-data mux: 0 = ALUOut, 1 = MDR
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = register A
alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2
alu_op  output  2  00 = add, 01 = sub, 10 = decode from funct
pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
state_dbg  output  STATE_W  current state encoding

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable and go to FETCH on the next edge.
- Reset: on a clk edge with rst_n=0, the state becomes FETCH.
  - While rst_n=0, pc_write, ir_write, mem_write, reg_write, branch and illegal_op are forced to 0.
  - All other outputs take their FETCH values: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, reg_dst=0, mem_to_reg=0.
  - state_dbg=0.
- Reset mid-instruction: the instruction is abandoned and no further write enable fires.
- Outputs are decoded from the state register. Any output not listed for a state is 0.
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready (gated, so they assert only in the completing cycle). Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
    - 100011 (lw) / 101011 (sw) → MEMADR
    - 000000 (R-type) → EXECUTE
    - 000100 (beq) → BRANCH
    - 001000 (addi) → ADDIEXEC
    - 000010 (j) → JUMP
    - any other opcode → FETCH, with illegal_op=1 for this cycle
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD if opcode=lw, else MEMWR.
  - MEMRD: iord=1. Hold while mem_ready=0, then go to MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Go to FETCH.
  - MEMWR: iord=1, mem_write=1 for the whole state. Hold while mem_ready=0, then go to FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Go to FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Go to FETCH.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Go to FETCH.
  - JUMP: pc_src=10, pc_write=1. Go to FETCH.
- Cycle counts with mem_ready tied high:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - illegal = 2
  - Each wait cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Invariants:
  - reg_write and mem_write are never asserted in the same cycle.
  - reg_write is asserted for exactly one cycle per lw/R-type/addi.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- opcode must remain stable from DECODE through MEMADR. The IR is not written outside FETCH, which guarantees this.

Test Plan:
- Reset and hold: rst_n=0 for 3 cycles with mem_ready=1 → state_dbg=0; pc_write, ir_write, reg_write and mem_write all stay 0. Release → pc_write=ir_write=1 in the first FETCH cycle.
- lw with 2 FETCH wait cycles and 1 MEMRD wait cycle, opcode=100011 → state sequence 0,0,0,1,2,3,3,4,0. reg_write=1, reg_dst=0 and mem_to_reg=1 only in state 4. ir_write high only in the third FETCH cycle.
- R-type, opcode=000000, mem_ready=1 → sequence 0,1,6,7,0. alu_op=10 in state 6. reg_dst=1 and reg_write=1 only in state 7.
- sw then beq, mem_ready=1 → sw: 0,1,2,5,0, with mem_write=1 only in state 5 and reg_write never asserted. beq: 0,1,8,0, with branch=1, pc_src=01, alu_op=01 in state 8.
- Illegal opcode 111111 → sequence 0,1,0. illegal_op=1 for exactly one cycle, in DECODE. No reg_write or mem_write.
- Reset mid-op: lw with rst_n dropped in MEMRD → next state 0. MEMWB never entered and reg_write never asserted. After release the FSM restarts at FETCH normally.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - Moore main control FSM for the multicycle MIPS datapath
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               branch,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t r_state;
  logic   w_op_legal;

  always_comb begin
    w_op_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: w_op_legal = 1'b1;
      default:                                       w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWR:    if (mem_ready) r_state <= S_FETCH;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_ADDIWB:   r_state <= S_FETCH;
        S_JUMP:     r_state <= S_FETCH;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  assign state_dbg = rst_n ? STATE_W'(r_state) : '0;

  // While reset is held, present FETCH datapath selects with every write enable low.
  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    illegal_op = 1'b0;
    if (!rst_n) begin
      alu_src_b = 2'b01;
    end else begin
      case (r_state)
        S_FETCH: begin
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          illegal_op = ~w_op_legal;
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEMRD:  iord = 1'b1;
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
        end
        S_MEMWR: begin
          iord      = 1'b1;
          mem_write = 1'b1;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_ALUWB: begin
          reg_dst   = 1'b1;
          reg_write = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_src    = 2'b01;
          branch    = 1'b1;
        end
        S_ADDIEXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_JUMP: begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - self-checking bench for multicycle_control_fsm
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state_dbg;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .branch(branch), .iord(iord), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
  } outs_t;

  typedef struct {
    logic [5:0] op;
    int         fw;
    int         mw;
    int         cycles;
    int         regw;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

  outs_t act;
  assign act = {pc_write, branch, iord, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};

  int checks = 0;
  int failures = 0;
  int plan[$];
  bit mrq[$];

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == JMP;
  endfunction

  // Expected control word for each named step of an instruction.
  function automatic outs_t exp_out(input int st, input bit mr, input logic [5:0] op, input bit in_rst);
    outs_t o = '0;
    if (in_rst) begin
      o.alu_src_b = 2'b01;
      return o;
    end
    case (st)
      0:  begin o.alu_src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      1:  begin o.alu_src_b = 2'b11; o.illegal_op = !is_legal(op); end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
      5:  begin o.iord = 1; o.mem_write = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_dst = 1; o.reg_write = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.branch = 1; end
      9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      10: o.reg_write = 1;
      11: begin o.pc_src = 2'b10; o.pc_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  // Expected sequence of state codes and the mem_ready value to drive in each cycle.
  task automatic push_wait(input int st, input int waits);
    for (int k = 0; k <= waits; k++) begin
      plan.push_back(st);
      mrq.push_back(k == waits);
    end
  endtask

  task automatic push_one(input int st);
    plan.push_back(st);
    mrq.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
    plan.delete();
    mrq.delete();
    push_wait(0, fw);
    push_one(1);
    case (op)
      LW:   begin push_one(2); push_wait(3, mw); push_one(4); end
      SW:   begin push_one(2); push_wait(5, mw); end
      RT:   begin push_one(6); push_one(7); end
      BEQ:  push_one(8);
      ADDI: begin push_one(9); push_one(10); end
      JMP:  push_one(11);
      default: ;
    endcase
  endtask

  function automatic int model_cycles(input logic [5:0] op, input int fw, input int mw);
    case (op)
      LW:      return 5 + fw + mw;
      SW:      return 4 + fw + mw;
      RT, ADDI: return 4 + fw;
      BEQ, JMP: return 3 + fw;
      default: return 2 + fw;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input string name, input int est, input bit mr, input logic [5:0] op, input bit in_rst);
    @(negedge clk);
    chk({name, ".state"}, int'(state_dbg), est);
    chk({name, ".outs"}, int'(act), int'(exp_out(est, mr, op, in_rst)));
  endtask

  task automatic run_instr(input string name, input logic [5:0] op, input int fw, input int mw,
                           input int cycles, input int exp_regw);
    int  meas = -1;
    int  regw = 0;
    bit  seen = 0;
    build_plan(op, fw, mw);
    for (int i = 0; i < plan.size(); i++) begin
      opcode    = (plan[i] == 0) ? 6'($urandom) : op;
      mem_ready = mrq[i];
      check_cycle(name, plan[i], mrq[i], op, 1'b0);
      if (state_dbg != 0) seen = 1;
      else if (seen && meas < 0) meas = i;
      if (reg_write) regw++;
      tick();
    end
    if (state_dbg == 0 && seen && meas < 0) meas = plan.size();
    chk({name, ".cycles"}, meas, cycles);
    chk({name, ".reg_write_count"}, regw, exp_regw);
  endtask

  vec_t vecs[$];
  logic [5:0] legal_ops[6] = '{LW, SW, RT, BEQ, ADDI, JMP};

  initial begin
    vecs = '{
      '{LW,      0, 0, 5, 1},
      '{SW,      0, 0, 4, 0},
      '{RT,      0, 0, 4, 1},
      '{ADDI,    0, 0, 4, 1},
      '{BEQ,     0, 0, 3, 0},
      '{JMP,     0, 0, 3, 0},
      '{6'h3f,   0, 0, 2, 0},
      '{LW,      2, 1, 8, 1},
      '{SW,      1, 2, 7, 0},
      '{6'b000001, 1, 0, 3, 0}
    };

    rst_n = 1'b0;
    mem_ready = 1'b1;
    opcode = JMP;
    for (int i = 0; i < 3; i++) begin
      check_cycle("reset_hold", 0, 1'b1, JMP, 1'b1);
      tick();
    end
    rst_n = 1'b1;
    run_instr("post_reset_j", JMP, 0, 0, 3, 0);

    foreach (vecs[i])
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].cycles, vecs[i].regw);

    // Reset dropped while lw waits in MEMRD: no write-back may follow.
    opcode = LW;
    mem_ready = 1'b1;
    check_cycle("midrst_fetch", 0, 1'b1, LW, 1'b0);
    tick();
    check_cycle("midrst_decode", 1, 1'b1, LW, 1'b0);
    tick();
    check_cycle("midrst_memadr", 2, 1'b1, LW, 1'b0);
    tick();
    mem_ready = 1'b0;
    check_cycle("midrst_memrd", 3, 1'b0, LW, 1'b0);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    check_cycle("midrst_held", 0, 1'b1, LW, 1'b1);
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    check_cycle("midrst_after", 0, 1'b0, LW, 1'b0);
    tick();
    run_instr("midrst_restart_rt", RT, 0, 0, 4, 1);

    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw, rw;
      op = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 5)];
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      rw = (op == LW || op == RT || op == ADDI) ? 1 : 0;
      run_instr($sformatf("rand%0d_op%0h", n, op), op, fw, mw, model_cycles(op, fw, mw), rw);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
